// File: rtl/zap_regfile_pkg.sv
// zap_regfile_pkg: shared ZAP localparams for the physical register file.
// Holds the register count, the read-as-zero sink index and the physical
// index map (architectural registers, banked R13/R14 copies, SPSRs).
package zap_regfile_pkg;

  localparam int DATA_W           = 32;
  localparam int PHY_REGS         = 46;
  localparam int PHY_AW           = $clog2(PHY_REGS);
  // Write sink / zero source; unused ports are parked here.
  localparam int PHY_RAZ_REGISTER = PHY_REGS - 1;

  // Architectural (user-mode) registers map 1:1 onto indices 0..15.
  localparam int ARCH_PC          = 15;

  // Banked FIQ R8..R14.
  localparam int PHY_FIQ_R8       = 16;
  localparam int PHY_FIQ_R9       = 17;
  localparam int PHY_FIQ_R10      = 18;
  localparam int PHY_FIQ_R11      = 19;
  localparam int PHY_FIQ_R12      = 20;
  localparam int PHY_FIQ_R13      = 21;
  localparam int PHY_FIQ_R14      = 22;

  // Banked R13/R14 for the remaining privileged modes.
  localparam int PHY_IRQ_R13      = 23;
  localparam int PHY_IRQ_R14      = 24;
  localparam int PHY_SVC_R13      = 25;
  localparam int PHY_SVC_R14      = 26;
  localparam int PHY_ABT_R13      = 27;
  localparam int PHY_ABT_R14      = 28;
  localparam int PHY_UND_R13      = 29;
  localparam int PHY_UND_R14      = 30;

  // Saved program status registers.
  localparam int PHY_FIQ_SPSR     = 31;
  localparam int PHY_IRQ_SPSR     = 32;
  localparam int PHY_SVC_SPSR     = 33;
  localparam int PHY_ABT_SPSR     = 34;
  localparam int PHY_UND_SPSR     = 35;

  // Scratch registers used by micro-op sequences.
  localparam int PHY_SCRATCH_0    = 36;

endpackage

// File: rtl/zap_regfile_if.sv
// zap_regfile_if: write/read bus of the ZAP register file.
//   i_wen                     common write enable for both write ports
//   i_wr_addr_a/i_wr_data_a   write port A (ALU side)
//   i_wr_addr_b/i_wr_data_b   write port B (load / SPSR side, wins on collision)
//   i_rd_addr_{a,b,c,d}       four independent read indices
//   o_rd_data_{a,b,c,d}       combinational read data
// master: the pipeline driving the file; slave: the register file itself.
interface zap_regfile_if
  import zap_regfile_pkg::*;
#(
  parameter int AW = PHY_AW
);

  logic              i_wen;
  logic [AW-1:0]     i_wr_addr_a;
  logic [DATA_W-1:0] i_wr_data_a;
  logic [AW-1:0]     i_wr_addr_b;
  logic [DATA_W-1:0] i_wr_data_b;
  logic [AW-1:0]     i_rd_addr_a;
  logic [AW-1:0]     i_rd_addr_b;
  logic [AW-1:0]     i_rd_addr_c;
  logic [AW-1:0]     i_rd_addr_d;
  logic [DATA_W-1:0] o_rd_data_a;
  logic [DATA_W-1:0] o_rd_data_b;
  logic [DATA_W-1:0] o_rd_data_c;
  logic [DATA_W-1:0] o_rd_data_d;

  modport master (
    output i_wen, i_wr_addr_a, i_wr_data_a, i_wr_addr_b, i_wr_data_b,
    output i_rd_addr_a, i_rd_addr_b, i_rd_addr_c, i_rd_addr_d,
    input  o_rd_data_a, o_rd_data_b, o_rd_data_c, o_rd_data_d
  );

  modport slave (
    input  i_wen, i_wr_addr_a, i_wr_data_a, i_wr_addr_b, i_wr_data_b,
    input  i_rd_addr_a, i_rd_addr_b, i_rd_addr_c, i_rd_addr_d,
    output o_rd_data_a, o_rd_data_b, o_rd_data_c, o_rd_data_d
  );

endinterface

// File: rtl/zap_regfile.sv
// zap_regfile: ZAP physical register file, PHY_REGS x 32-bit flops.
//   i_clk    core clock, all updates on the rising edge
//   i_reset  synchronous active-high reset, clears every entry
//   bus      zap_regfile_if slave: two write ports sharing i_wen,
//            four combinational read ports
// Reads do not bypass same-cycle writes. The RAZ index and any index at or
// above PHY_REGS swallow writes and read back as zero.
module zap_regfile
  import zap_regfile_pkg::*;
#(
  parameter int PHY_REGS = zap_regfile_pkg::PHY_REGS,
  parameter int AW       = $clog2(PHY_REGS)
) (
  input  logic        i_clk,
  input  logic        i_reset,
  zap_regfile_if.slave bus
);

  localparam logic [AW-1:0] RAZ_IDX = AW'(PHY_RAZ_REGISTER);
  // One extra bit so the bound also works when PHY_REGS is a power of two.
  localparam logic [AW:0]   LIMIT   = (AW+1)'(PHY_REGS);

  logic [DATA_W-1:0] mem_q [PHY_REGS];
  logic [DATA_W-1:0] mem_d [PHY_REGS];

  function automatic logic live_idx(input logic [AW-1:0] a);
    return ({1'b0, a} < LIMIT) && (a != RAZ_IDX);
  endfunction

  always_comb begin
    mem_d = mem_q;
    if (bus.i_wen) begin
      if (live_idx(bus.i_wr_addr_a)) mem_d[bus.i_wr_addr_a] = bus.i_wr_data_a;
      // Port B is applied last so load data wins an address collision.
      if (live_idx(bus.i_wr_addr_b)) mem_d[bus.i_wr_addr_b] = bus.i_wr_data_b;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < PHY_REGS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign bus.o_rd_data_a = live_idx(bus.i_rd_addr_a) ? mem_q[bus.i_rd_addr_a] : '0;
  assign bus.o_rd_data_b = live_idx(bus.i_rd_addr_b) ? mem_q[bus.i_rd_addr_b] : '0;
  assign bus.o_rd_data_c = live_idx(bus.i_rd_addr_c) ? mem_q[bus.i_rd_addr_c] : '0;
  assign bus.o_rd_data_d = live_idx(bus.i_rd_addr_d) ? mem_q[bus.i_rd_addr_d] : '0;

endmodule

// File: tb/tb_zap_regfile.sv
// tb_zap_regfile: directed bench for zap_regfile with a reference model and
// a scoreboard queue of expected read results.
module tb_zap_regfile;

  localparam int NREG = 46;
  localparam int RAZ  = 45;

  logic i_clk = 1'b0;
  logic i_reset;

  zap_regfile_if #(.AW(6)) bus ();

  zap_regfile dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t         sb_q [$];
  logic [31:0] mdl [64];
  int          total = 0;
  int          bad   = 0;

  function automatic logic [31:0] mdl_rd(input int a);
    if (a < NREG && a != RAZ) return mdl[a];
    return 32'h0;
  endfunction

  task automatic apply(input logic rst, input logic wen,
                       input int aa, input logic [31:0] da,
                       input int ab, input logic [31:0] db);
    i_reset         = rst;
    bus.i_wen       = wen;
    bus.i_wr_addr_a = 6'(aa);
    bus.i_wr_data_a = da;
    bus.i_wr_addr_b = 6'(ab);
    bus.i_wr_data_b = db;
  endtask

  // One rising edge; the model follows what the inputs asked for.
  task automatic tick();
    int aa, ab;
    @(posedge i_clk);
    aa = int'(bus.i_wr_addr_a);
    ab = int'(bus.i_wr_addr_b);
    if (i_reset) begin
      for (int i = 0; i < 64; i++) mdl[i] = 32'h0;
    end else if (bus.i_wen) begin
      if (aa < NREG && aa != RAZ) mdl[aa] = bus.i_wr_data_a;
      if (ab < NREG && ab != RAZ) mdl[ab] = bus.i_wr_data_b;
    end
    @(negedge i_clk);
  endtask

  task automatic check_reads(input string name, input int ra, input int rb,
                             input int rc, input int rd);
    logic [31:0] obs [4];
    int          adr [4];
    sb_t         e;
    adr = '{ra, rb, rc, rd};
    bus.i_rd_addr_a = 6'(ra);
    bus.i_rd_addr_b = 6'(rb);
    bus.i_rd_addr_c = 6'(rc);
    bus.i_rd_addr_d = 6'(rd);
    for (int p = 0; p < 4; p++)
      sb_q.push_back('{$sformatf("%s.port%0d@%0d", name, p, adr[p]), mdl_rd(adr[p])});
    #1;
    obs = '{bus.o_rd_data_a, bus.o_rd_data_b, bus.o_rd_data_c, bus.o_rd_data_d};
    for (int p = 0; p < 4; p++) begin
      e = sb_q.pop_front();
      total++;
      assert (obs[p] === e.exp)
        else begin
          bad++;
          $error("FAIL %s observed=%h expected=%h", e.tag, obs[p], e.exp);
        end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 64; i++) mdl[i] = 32'hBAD0_0000 | i;
    bus.i_rd_addr_a = 6'd0;
    bus.i_rd_addr_b = 6'd0;
    bus.i_rd_addr_c = 6'd0;
    bus.i_rd_addr_d = 6'd0;

    // Reset while a write is also requested: reset must win.
    apply(1'b1, 1'b1, 3, 32'hAAAA_AAAA, 4, 32'hBBBB_BBBB);
    tick();
    tick();
    check_reads("reset_in", 0, 3, 4, 5);

    // First write lands on the first edge with reset released.
    apply(1'b0, 1'b1, 3, 32'hDEAD_BEEF, 7, 32'h1234_5678);
    check_reads("after_reset", 0, 5, 17, 44);
    check_reads("pre_edge_no_bypass", 3, 7, 3, 7);
    tick();
    apply(1'b0, 1'b0, RAZ, 32'h0, RAZ, 32'h0);
    check_reads("post_write", 3, 7, 3, 7);
    check_reads("multi_port", 3, 3, 7, 63);

    // Same address on both ports: B wins.
    apply(1'b0, 1'b1, 9, 32'h1111_1111, 9, 32'h2222_2222);
    tick();
    apply(1'b0, 1'b0, RAZ, 32'h0, RAZ, 32'h0);
    check_reads("collision", 9, 9, 3, 7);

    // Writes to the RAZ sink are discarded.
    apply(1'b0, 1'b1, RAZ, 32'hFFFF_FFFF, RAZ, 32'hFFFF_FFFF);
    tick();
    apply(1'b0, 1'b0, RAZ, 32'h0, RAZ, 32'h0);
    check_reads("raz", 45, 3, 7, 9);
    check_reads("raz_neighbours", 44, 0, 1, 2);

    // Out-of-range write addresses are ignored, reads return zero.
    apply(1'b0, 1'b1, 50, 32'h5050_5050, 63, 32'h6363_6363);
    tick();
    apply(1'b0, 1'b0, RAZ, 32'h0, RAZ, 32'h0);
    check_reads("out_of_range", 50, 63, 46, 3);

    // Write enable low: nothing moves even with live addresses and data.
    apply(1'b0, 1'b0, 3, 32'hCAFE_F00D, 7, 32'hCAFE_F00D);
    tick();
    check_reads("wen_low", 3, 7, 9, 45);

    // Boundary entries 0 and 44 via both ports.
    apply(1'b0, 1'b1, 0, 32'h0000_0A0A, 44, 32'h4444_0044);
    tick();
    apply(1'b0, 1'b0, RAZ, 32'h0, RAZ, 32'h0);
    check_reads("edges", 0, 44, 44, 0);

    // Pseudo-random traffic over the full 6-bit address space.
    for (int n = 0; n < 12; n++) begin
      apply(1'b0, 1'($urandom_range(0, 3) != 0),
            int'($urandom_range(0, 63)), $urandom(),
            int'($urandom_range(0, 63)), $urandom());
      tick();
      check_reads($sformatf("rand%0d", n),
                  int'($urandom_range(0, 63)), int'($urandom_range(0, 47)),
                  int'($urandom_range(0, 47)), int'($urandom_range(0, 47)));
    end

    // Reset with a simultaneous write clears everything.
    apply(1'b1, 1'b1, 3, 32'h7777_7777, 7, 32'h8888_8888);
    tick();
    apply(1'b0, 1'b0, RAZ, 32'h0, RAZ, 32'h0);
    check_reads("reset_with_wen", 3, 7, 9, 0);
    check_reads("reset_clear", 44, 17, 5, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
